// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - stopwatch run/pause/adjust sequencer with MM:SS BCD time and adjust-field blink
module stopwatch_ctrl #(
    parameter int TICK_DIV  = 100_000_000,
    parameter int ADJ_DIV   = 50_000_000,
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_pause,
    input  logic       btn_rst,
    input  logic       adj,
    input  logic       sel,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic [3:0] digit_blank,
    output logic       running
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int AW = (ADJ_DIV > 1) ? $clog2(ADJ_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [TW-1:0] TICK_MAX  = TW'(TICK_DIV - 1);
    localparam logic [AW-1:0] ADJ_MAX   = AW'(ADJ_DIV - 1);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_PAUSE  = 2'd2,
        S_ADJUST = 2'd3
    } state_t;

    state_t state, state_next;

    logic [TW-1:0] tick_cnt;
    logic [AW-1:0] adj_cnt;
    logic [BW-1:0] blink_cnt;
    logic          blink;
    logic          sel_q;

    logic          tick_wrap;
    logic          adj_wrap;
    logic          adj_entry;
    logic          sel_change;
    logic          blink_wrap;
    logic          blink_next;

    logic [3:0]    mt_n, mo_n, st_n, so_n;

    // btn_rst dominates, then adj; btn_pause only matters outside ADJUST
    always_comb begin
        state_next = state;
        if (btn_rst) begin
            state_next = adj ? S_ADJUST : S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (adj)            state_next = S_ADJUST;
                    else if (btn_pause) state_next = S_RUN;
                end
                S_RUN: begin
                    if (adj)            state_next = S_ADJUST;
                    else if (btn_pause) state_next = S_PAUSE;
                end
                S_PAUSE: begin
                    if (adj)            state_next = S_ADJUST;
                    else if (btn_pause) state_next = S_RUN;
                end
                S_ADJUST: begin
                    if (!adj)           state_next = S_PAUSE;
                end
                default:                state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    assign tick_wrap  = (state == S_RUN) && (tick_cnt == TICK_MAX);
    assign adj_entry  = (state_next == S_ADJUST) && (state != S_ADJUST);
    assign sel_change = sel ^ sel_q;
    assign adj_wrap   = (state == S_ADJUST) && !sel_change && (adj_cnt == ADJ_MAX);
    assign blink_wrap = (blink_cnt == BLINK_MAX);
    assign blink_next = blink ^ blink_wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else if (btn_rst || (state_next == S_ADJUST)) begin
            tick_cnt <= '0;
        end else if (state == S_RUN) begin
            tick_cnt <= tick_wrap ? '0 : tick_cnt + TW'(1);
        end
    end

    // A sel change restarts the adjust interval so the new field gets a full period
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adj_cnt <= '0;
            sel_q   <= 1'b0;
        end else begin
            sel_q <= sel;
            if (btn_rst || adj_entry || sel_change) begin
                adj_cnt <= '0;
            end else if (state == S_ADJUST) begin
                adj_cnt <= adj_wrap ? '0 : adj_cnt + AW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt <= '0;
            blink     <= 1'b0;
        end else begin
            blink_cnt <= blink_wrap ? '0 : blink_cnt + BW'(1);
            blink     <= blink_next;
        end
    end

    // Seconds adjust wraps 59 -> 00 without carrying into minutes
    always_comb begin
        mt_n = min_tens;
        mo_n = min_ones;
        st_n = sec_tens;
        so_n = sec_ones;
        if (btn_rst) begin
            mt_n = 4'd0;
            mo_n = 4'd0;
            st_n = 4'd0;
            so_n = 4'd0;
        end else if (tick_wrap) begin
            if (sec_ones != 4'd9) begin
                so_n = sec_ones + 4'd1;
            end else begin
                so_n = 4'd0;
                if (sec_tens != 4'd5) begin
                    st_n = sec_tens + 4'd1;
                end else begin
                    st_n = 4'd0;
                    if (min_ones != 4'd9) begin
                        mo_n = min_ones + 4'd1;
                    end else begin
                        mo_n = 4'd0;
                        mt_n = (min_tens == 4'd9) ? 4'd0 : min_tens + 4'd1;
                    end
                end
            end
        end else if (adj_wrap) begin
            if (sel) begin
                if (sec_ones != 4'd9) begin
                    so_n = sec_ones + 4'd1;
                end else begin
                    so_n = 4'd0;
                    st_n = (sec_tens == 4'd5) ? 4'd0 : sec_tens + 4'd1;
                end
            end else begin
                if (min_ones != 4'd9) begin
                    mo_n = min_ones + 4'd1;
                end else begin
                    mo_n = 4'd0;
                    mt_n = (min_tens == 4'd9) ? 4'd0 : min_tens + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_tens    <= 4'd0;
            min_ones    <= 4'd0;
            sec_tens    <= 4'd0;
            sec_ones    <= 4'd0;
            digit_blank <= 4'b0000;
            running     <= 1'b0;
        end else begin
            min_tens <= mt_n;
            min_ones <= mo_n;
            sec_tens <= st_n;
            sec_ones <= so_n;
            running  <= (state_next == S_RUN);
            if ((state_next == S_ADJUST) && blink_next) begin
                digit_blank <= sel ? 4'b0011 : 4'b1100;
            end else begin
                digit_blank <= 4'b0000;
            end
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - directed and randomized checks of stopwatch_ctrl against a behavioural model
module tb_stopwatch_ctrl;

    localparam int TICK  = 4;
    localparam int ADJD  = 3;
    localparam int BLINK = 2;

    localparam int ST_IDLE  = 0;
    localparam int ST_RUN   = 1;
    localparam int ST_PAUSE = 2;
    localparam int ST_ADJ   = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       btn_pause = 1'b0;
    logic       btn_rst = 1'b0;
    logic       adj = 1'b0;
    logic       sel = 1'b0;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic [3:0] digit_blank;
    logic       running;

    int n_assert = 0;
    int n_fail   = 0;

    int m_state, m_min, m_sec, m_run_cycles, m_adj_cycles, m_edges, m_blank;
    logic m_sel_prev;

    stopwatch_ctrl #(
        .TICK_DIV (TICK),
        .ADJ_DIV  (ADJD),
        .BLINK_DIV(BLINK)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_pause  (btn_pause),
        .btn_rst    (btn_rst),
        .adj        (adj),
        .sel        (sel),
        .min_tens   (min_tens),
        .min_ones   (min_ones),
        .sec_tens   (sec_tens),
        .sec_ones   (sec_ones),
        .digit_blank(digit_blank),
        .running    (running)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int dut_digits();
        return int'({min_tens, min_ones, sec_tens, sec_ones});
    endfunction

    function automatic int model_digits();
        return ((m_min / 10) << 12) | ((m_min % 10) << 8) | ((m_sec / 10) << 4) | (m_sec % 10);
    endfunction

    task automatic model_reset();
        m_state      = ST_IDLE;
        m_min        = 0;
        m_sec        = 0;
        m_run_cycles = 0;
        m_adj_cycles = 0;
        m_edges      = 0;
        m_blank      = 0;
        m_sel_prev   = 1'b0;
    endtask

    task automatic model_step();
        int ns;
        m_edges++;
        if (btn_rst) begin
            m_min = 0;
            m_sec = 0;
            m_run_cycles = 0;
            m_adj_cycles = 0;
            ns = adj ? ST_ADJ : ST_IDLE;
        end else begin
            ns = m_state;
            if (m_state == ST_ADJ) begin
                if (!adj) ns = ST_PAUSE;
            end else if (adj) begin
                ns = ST_ADJ;
            end else if (btn_pause) begin
                ns = (m_state == ST_RUN) ? ST_PAUSE : ST_RUN;
            end
            if (m_state == ST_RUN) begin
                m_run_cycles++;
                if (m_run_cycles == TICK) begin
                    m_run_cycles = 0;
                    m_sec++;
                    if (m_sec == 60) begin
                        m_sec = 0;
                        m_min = (m_min + 1) % 100;
                    end
                end
            end
            if (sel != m_sel_prev) begin
                m_adj_cycles = 0;
            end else if (m_state == ST_ADJ) begin
                m_adj_cycles++;
                if (m_adj_cycles == ADJD) begin
                    m_adj_cycles = 0;
                    if (sel) m_sec = (m_sec + 1) % 60;
                    else     m_min = (m_min + 1) % 100;
                end
            end
            if (ns == ST_ADJ && m_state != ST_ADJ) begin
                m_run_cycles = 0;
                m_adj_cycles = 0;
            end
        end
        m_sel_prev = sel;
        m_state    = ns;
        m_blank    = (ns == ST_ADJ && ((m_edges / BLINK) % 2) == 1) ? (sel ? 4'b0011 : 4'b1100) : 0;
    endtask

    // One clock: model follows the sampled inputs, outputs compared at the falling edge
    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("digits", dut_digits(), model_digits());
        chk("running", int'(running), (m_state == ST_RUN) ? 1 : 0);
        chk("digit_blank", int'(digit_blank), m_blank);
        btn_pause = 1'b0;
        btn_rst   = 1'b0;
    endtask

    task automatic run_until(input int mm, input int ss, input int limit);
        int n = 0;
        while ((m_min != mm || m_sec != ss) && n < limit) begin
            cyc();
            n++;
        end
        chk("reach_target_in_budget", (n < limit) ? 1 : 0, 1);
    endtask

    initial begin
        int cnt_on, cnt_off;
        model_reset();

        // Power-on reset
        #3 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_digits", dut_digits(), 16'h0000);
        chk("reset_running", int'(running), 0);
        chk("reset_blank", int'(digit_blank), 0);
        rst_n = 1'b1;

        // Count from 00:00 through the first minute carry
        btn_pause = 1'b1;
        cyc();
        chk("run_start_running", int'(running), 1);
        repeat (4 * 59) cyc();
        chk("run_00_59", dut_digits(), 16'h0059);
        repeat (3) cyc();
        chk("run_before_carry", dut_digits(), 16'h0059);
        cyc();
        chk("run_01_00", dut_digits(), 16'h0100);

        // Reset and pause together while running at 03:27
        run_until(3, 27, 1000);
        chk("run_03_27", dut_digits(), 16'h0327);
        btn_rst = 1'b1;
        btn_pause = 1'b1;
        cyc();
        chk("rst_pause_digits", dut_digits(), 16'h0000);
        chk("rst_pause_running", int'(running), 0);
        repeat (4) cyc();
        chk("idle_holds_zero", dut_digits(), 16'h0000);
        chk("idle_not_running", int'(running), 0);

        // Same collision with adj high lands in ADJUST
        btn_pause = 1'b1;
        cyc();
        repeat (3) cyc();
        sel = 1'b1;
        adj = 1'b1;
        btn_rst = 1'b1;
        btn_pause = 1'b1;
        cyc();
        chk("rst_adj_digits", dut_digits(), 16'h0000);
        chk("rst_adj_running", int'(running), 0);

        // Seconds adjust wraps without touching minutes
        run_until(0, 58, 400);
        repeat (2) cyc();
        chk("adj_sec_hold", dut_digits(), 16'h0058);
        cyc();
        chk("adj_sec_59", dut_digits(), 16'h0059);
        repeat (3) cyc();
        chk("adj_sec_wrap", dut_digits(), 16'h0000);
        sel = 1'b0;
        repeat (3) cyc();
        chk("adj_min_hold", dut_digits(), 16'h0000);
        cyc();
        chk("adj_min_01", dut_digits(), 16'h0100);
        cnt_on = 0;
        cnt_off = 0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (digit_blank == 4'b1100) cnt_on++;
            else if (digit_blank == 4'b0000) cnt_off++;
        end
        chk("blank_sel0_on", cnt_on, 2);
        chk("blank_sel0_off", cnt_off, 2);

        // Preload 99:59 and let one tick roll it over
        run_until(99, 0, 600);
        sel = 1'b1;
        run_until(99, 59, 400);
        chk("preload_99_59", dut_digits(), 16'h9959);
        adj = 1'b0;
        cyc();
        chk("adj_exit_pause", int'(running), 0);
        chk("adj_exit_keeps", dut_digits(), 16'h9959);
        btn_pause = 1'b1;
        cyc();
        chk("resume_running", int'(running), 1);
        repeat (3) cyc();
        chk("wrap_hold", dut_digits(), 16'h9959);
        cyc();
        chk("wrap_00_00", dut_digits(), 16'h0000);

        // Pause keeps the partial prescaler count
        btn_rst = 1'b1;
        cyc();
        btn_pause = 1'b1;
        cyc();
        repeat (5) cyc();
        chk("pr_00_01", dut_digits(), 16'h0001);
        btn_pause = 1'b1;
        cyc();
        chk("pr_paused", int'(running), 0);
        repeat (20) cyc();
        chk("pr_hold", dut_digits(), 16'h0001);
        btn_pause = 1'b1;
        cyc();
        chk("pr_resumed", int'(running), 1);
        cyc();
        chk("pr_partial", dut_digits(), 16'h0001);
        cyc();
        chk("pr_00_02", dut_digits(), 16'h0002);

        // Asynchronous reset mid-run at 12:34
        adj = 1'b1;
        sel = 1'b0;
        btn_rst = 1'b1;
        cyc();
        run_until(12, 0, 200);
        sel = 1'b1;
        run_until(12, 34, 200);
        adj = 1'b0;
        cyc();
        btn_pause = 1'b1;
        cyc();
        repeat (2) cyc();
        chk("pre_rst_12_34", dut_digits(), 16'h1234);
        chk("pre_rst_running", int'(running), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_digits", dut_digits(), 16'h0000);
        chk("async_rst_running", int'(running), 0);
        chk("async_rst_blank", int'(digit_blank), 0);
        model_reset();
        sel = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) cyc();
        chk("post_rst_idle", dut_digits(), 16'h0000);
        btn_pause = 1'b1;
        cyc();
        repeat (4) cyc();
        chk("post_rst_count", dut_digits(), 16'h0001);

        // Randomized input mix checked cycle by cycle against the model
        for (int i = 0; i < 600; i++) begin
            btn_pause = ($urandom_range(0, 7) == 0);
            btn_rst   = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 19) == 0) adj = ~adj;
            if ($urandom_range(0, 14) == 0) sel = ~sel;
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
